// File: rtl/pea_pkg.sv
// Shared types and helpers for the PEA processing elements.
package pea_pkg;

    // Lane partitioning of the datapath; 2'b11 is not a member and is treated as VEC_NONE.
    typedef enum logic [1:0] {
        VEC_NONE = 2'b00,
        VEC_8    = 2'b01,
        VEC_16   = 2'b10
    } vec_mode_t;

    // Accumulate, two reduction stages, then hold the result for the consumer.
    typedef enum logic [1:0] {
        ACC,
        RED2,
        RED1,
        HOLD
    } vacc_state_t;

    // Number of independent lanes for a raw vec_mode encoding.
    function automatic int unsigned lane_count(input logic [1:0] mode);
        case (mode)
            VEC_8:   return 4;
            VEC_16:  return 2;
            default: return 1;
        endcase
    endfunction

endpackage

// File: rtl/vacc_lane_mac.sv
// Combinational partitioned signed multiply-add: res = f(acc + a*b) per lane,
// with f either clamping to the lane range or keeping the low lane bits.
module vacc_lane_mac
    import pea_pkg::*;
#(
    parameter int unsigned N_BITS = 32
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic [N_BITS-1:0] acc,
    input  logic [1:0]        mode,
    input  logic              sat_en,
    output logic [N_BITS-1:0] res
);

    // Row m holds the full-width result for a split into 2**m lanes.
    logic [2:0][N_BITS-1:0] cfg_res;

    for (genvar m = 0; m < 3; m++) begin : g_cfg
        localparam int unsigned LANES = 1 << m;
        localparam int unsigned W     = N_BITS / LANES;

        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic [W-1:0]          la;
            logic [W-1:0]          lb;
            logic [W-1:0]          lc;
            logic signed [2*W-1:0] prod;
            logic signed [2*W:0]   sum;
            logic                  ovf;

            assign la   = a[l*W +: W];
            assign lb   = b[l*W +: W];
            assign lc   = acc[l*W +: W];
            assign prod = $signed({{W{la[W-1]}}, la}) * $signed({{W{lb[W-1]}}, lb});
            assign sum  = $signed({{(W+1){lc[W-1]}}, lc}) + $signed({prod[2*W-1], prod});
            // Out of lane range unless everything above the lane sign bit matches it.
            assign ovf  = (sum[2*W:W-1] != '0) && (sum[2*W:W-1] != '1);
            assign cfg_res[m][l*W +: W] =
                (sat_en && ovf) ? (sum[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                                : sum[W-1:0];
        end
    end

    // Pick the lane split requested by the mode.
    always_comb begin
        case (mode)
            VEC_8:   res = cfg_res[2];
            VEC_16:  res = cfg_res[1];
            default: res = cfg_res[0];
        endcase
    end

endmodule

// File: rtl/vacc_pe.sv
// Vector multiply-accumulate PE: self-counted accumulation over acc_len beats,
// pipelined lane reduction and a valid/ready result handshake.
module vacc_pe
    import pea_pkg::*;
#(
    parameter int unsigned N_BITS      = 32,
    parameter int unsigned N_INPUTS_PE = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [N_INPUTS_PE*N_BITS-1:0]    pe_op_i,
    input  logic [N_INPUTS_PE-1:0]           stream_valid_i,
    input  logic [$clog2(N_INPUTS_PE)-1:0]   mux1_sel_i,
    input  logic [$clog2(N_INPUTS_PE)-1:0]   mux2_sel_i,
    input  logic [1:0]                       vec_mode_i,
    input  logic                             sat_en_i,
    input  logic [CNT_W-1:0]                 acc_len_i,
    output logic                             in_ready_o,
    input  logic                             res_ready_i,
    output logic                             stream_valid_o,
    output logic [N_BITS-1:0]                pe_res_o
);

    localparam int unsigned QW = N_BITS / 4;
    localparam int unsigned HW = N_BITS / 2;

    vacc_state_t state;
    vacc_state_t state_next;

    logic [N_INPUTS_PE-1:0][N_BITS-1:0] ops;
    logic [N_BITS-1:0] op_a;
    logic [N_BITS-1:0] op_b;
    logic [N_BITS-1:0] acc;
    logic [N_BITS-1:0] acc_base;
    logic [N_BITS-1:0] mac_res;
    logic [N_BITS-1:0] part_lo;
    logic [N_BITS-1:0] part_hi;
    logic [N_BITS-1:0] red_a;
    logic [N_BITS-1:0] red_b;
    logic [N_BITS-1:0] red_sum;
    logic signed [QW:0] pair_lo;
    logic signed [QW:0] pair_hi;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_eff;
    logic [1:0]       mode_q;
    logic [1:0]       mode_eff;
    logic             sat_q;
    logic             sat_eff;
    logic             first;
    logic             accept;
    logic             last_beat;
    logic             handshake;

    assign ops  = pe_op_i;
    assign op_a = ops[mux1_sel_i];
    assign op_b = ops[mux2_sel_i];

    // Config is live on the first beat and frozen for the rest of the accumulation.
    assign first    = (cnt == '0);
    assign mode_eff = first ? vec_mode_i : mode_q;
    assign sat_eff  = first ? sat_en_i   : sat_q;
    assign len_eff  = first ? acc_len_i  : len_q;

    assign in_ready_o = (state == ACC);
    assign accept     = (state == ACC) && stream_valid_i[mux1_sel_i] && stream_valid_i[mux2_sel_i];
    assign last_beat  = (len_eff == '0) || (cnt == len_eff - CNT_W'(1));
    assign handshake  = (state == HOLD) && stream_valid_o && res_ready_i;

    // First beat starts from zero so nothing leaks from an earlier accumulation.
    assign acc_base = first ? '0 : acc;

    vacc_lane_mac #(
        .N_BITS (N_BITS)
    ) u_lane_mac (
        .a      (op_a),
        .b      (op_b),
        .acc    (acc_base),
        .mode   (mode_eff),
        .sat_en (sat_eff),
        .res    (mac_res)
    );

    // Stage 1: exact pairwise sums of the four quarter lanes.
    assign pair_lo = $signed({acc[QW-1], acc[QW-1:0]})     + $signed({acc[2*QW-1], acc[2*QW-1:QW]});
    assign pair_hi = $signed({acc[3*QW-1], acc[3*QW-1:2*QW]}) + $signed({acc[N_BITS-1], acc[N_BITS-1:3*QW]});

    // Stage 2 operands: half lanes straight from the accumulator, else the stage-1 partials.
    assign red_a = (lane_count(mode_q) == 2) ? {{HW{acc[HW-1]}}, acc[HW-1:0]}         : part_lo;
    assign red_b = (lane_count(mode_q) == 2) ? {{HW{acc[N_BITS-1]}}, acc[N_BITS-1:HW]} : part_hi;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: the lane count of the finished accumulation picks the reduction depth.
    always_comb begin
        state_next = state;
        case (state)
            ACC: begin
                if (accept && last_beat) begin
                    case (lane_count(mode_eff))
                        4:       state_next = RED2;
                        2:       state_next = RED1;
                        default: state_next = HOLD;
                    endcase
                end
            end
            RED2:    state_next = RED1;
            RED1:    state_next = HOLD;
            HOLD:    if (handshake) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // Beat counter and per-accumulation config capture.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt    <= '0;
            len_q  <= '0;
            mode_q <= '0;
            sat_q  <= 1'b0;
        end else if (accept) begin
            if (first) begin
                len_q  <= acc_len_i;
                mode_q <= vec_mode_i;
                sat_q  <= sat_en_i;
            end
            cnt <= last_beat ? '0 : cnt + CNT_W'(1);
        end
    end

    // Lane accumulator: updated per accepted beat, cleared once the result is taken.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc <= '0;
        end else if (accept) begin
            acc <= mac_res;
        end else if (handshake) begin
            acc <= '0;
        end
    end

    // Reduction pipeline registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            part_lo <= '0;
            part_hi <= '0;
            red_sum <= '0;
        end else begin
            if (state == RED2) begin
                part_lo <= {{(N_BITS-QW-1){pair_lo[QW]}}, pair_lo};
                part_hi <= {{(N_BITS-QW-1){pair_hi[QW]}}, pair_hi};
            end
            if (state == RED1) begin
                red_sum <= red_a + red_b;
            end
        end
    end

    // Output register: loads on the first HOLD cycle, drops valid after the handshake.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stream_valid_o <= 1'b0;
            pe_res_o       <= '0;
        end else if (state == HOLD) begin
            if (!stream_valid_o) begin
                stream_valid_o <= 1'b1;
                pe_res_o       <= (lane_count(mode_q) == 1) ? acc : red_sum;
            end else if (res_ready_i) begin
                stream_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vacc_pe.sv
// Directed and randomised bench for vacc_pe with a result scoreboard.
module tb_vacc_pe;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic [7:0][31:0] pe_op;
    logic [7:0]       stream_valid_i;
    logic [2:0]       mux1_sel_i;
    logic [2:0]       mux2_sel_i;
    logic [1:0]       vec_mode_i;
    logic             sat_en_i;
    logic [15:0]      acc_len_i;
    logic             in_ready_o;
    logic             res_ready_i;
    logic             stream_valid_o;
    logic [31:0]      pe_res_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    exp_t        sb[$];
    logic [31:0] last_exp;
    logic [2:0]  sel_a;
    logic [2:0]  sel_b;
    int          m_lanes;
    bit          m_sat;
    longint      m_lane[4];
    bit          prev_valid = 1'b0;
    bit          drop_due   = 1'b0;

    vacc_pe #(
        .N_BITS      (32),
        .N_INPUTS_PE (8),
        .CNT_W       (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .pe_op_i        (pe_op),
        .stream_valid_i (stream_valid_i),
        .mux1_sel_i     (mux1_sel_i),
        .mux2_sel_i     (mux2_sel_i),
        .vec_mode_i     (vec_mode_i),
        .sat_en_i       (sat_en_i),
        .acc_len_i      (acc_len_i),
        .in_ready_o     (in_ready_o),
        .res_ready_i    (res_ready_i),
        .stream_valid_o (stream_valid_o),
        .pe_res_o       (pe_res_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic longint sext_low(input longint v, input int w);
        longint t;
        longint half;
        half = 64'sd1 <<< (w - 1);
        t = v & ((half <<< 1) - 1);
        if (t >= half) t = t - (half <<< 1);
        return t;
    endfunction

    function automatic longint lane_val(input logic [31:0] v, input int l, input int w);
        longint t;
        t = longint'({32'b0, v}) >> (l * w);
        return sext_low(t, w);
    endfunction

    function automatic void model_clear();
        for (int l = 0; l < 4; l++) m_lane[l] = 0;
    endfunction

    function automatic void model_beat(input logic [31:0] a, input logic [31:0] b);
        int     w;
        longint s;
        longint hi;
        longint lo;
        w  = 32 / m_lanes;
        hi = (64'sd1 <<< (w - 1)) - 1;
        lo = -(64'sd1 <<< (w - 1));
        for (int l = 0; l < m_lanes; l++) begin
            s = m_lane[l] + lane_val(a, l, w) * lane_val(b, l, w);
            if (m_sat) s = (s > hi) ? hi : ((s < lo) ? lo : s);
            else       s = sext_low(s, w);
            m_lane[l] = s;
        end
    endfunction

    function automatic logic [31:0] model_result();
        longint sum = 0;
        for (int l = 0; l < m_lanes; l++) sum += m_lane[l];
        return sum[31:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start(input logic [1:0] mode, input bit sat, input logic [15:0] len);
        vec_mode_i = mode;
        sat_en_i   = sat;
        acc_len_i  = len;
        m_lanes    = (mode == 2'b01) ? 4 : ((mode == 2'b10) ? 2 : 1);
        m_sat      = sat;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 8; i++) pe_op[i] = $urandom;
        pe_op[sel_a]   = a;
        pe_op[sel_b]   = b;
        mux1_sel_i     = sel_a;
        mux2_sel_i     = sel_b;
        stream_valid_i = 8'($urandom);
        stream_valid_i[sel_a] = 1'b1;
        stream_valid_i[sel_b] = 1'b1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int unsigned guard = 0;
        drive(a, b);
        while (!in_ready_o && guard < 40) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (!in_ready_o) check("send_ready_timeout", {31'b0, in_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        stream_valid_i = '0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input bit last);
        exp_t e;
        send(a, b);
        model_beat(pe_op[sel_a], pe_op[sel_b]);
        if (last) begin
            e.res     = model_result();
            e.acc_cyc = cyc;
            e.lat     = (m_lanes == 4) ? 3 : ((m_lanes == 2) ? 2 : 1);
            last_exp  = e.res;
            sb.push_back(e);
            model_clear();
        end
    endtask

    task automatic wait_idle();
        int unsigned guard = 0;
        while ((sb.size() != 0 || stream_valid_o) && guard < 60) begin
            @(posedge clk_i); #1;
            guard++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            drop_due = 1'b0;
        end else begin
            if (stream_valid_o && !prev_valid) begin
                n_checks++;
                assert (sb.size() > 0) n_pass++;
                else $error("FAIL unexpected_valid: observed result %0h, expected no result", pe_res_o);
                if (sb.size() > 0) begin
                    check("result", pe_res_o, sb[0].res);
                    check("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
                end
            end
            if (drop_due) check("valid_drop", {31'b0, stream_valid_o}, 32'd0);
            drop_due = stream_valid_o && res_ready_i;
            if (stream_valid_o && res_ready_i && sb.size() > 0) void'(sb.pop_front());
        end
        prev_valid = stream_valid_o;
    end

    // ---------------- directed sequence ----------------
    initial begin
        exp_t e;
        int unsigned guard;

        rst_n_i        = 1'b0;
        pe_op          = '0;
        stream_valid_i = '0;
        mux1_sel_i     = '0;
        mux2_sel_i     = '0;
        res_ready_i    = 1'b1;
        sel_a          = 3'd2;
        sel_b          = 3'd5;
        start(2'b00, 1'b0, 16'd1);
        model_clear();

        #12;
        check("rst_valid", {31'b0, stream_valid_o}, 32'd0);
        check("rst_res", pe_res_o, 32'd0);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        check("rst_in_ready", {31'b0, in_ready_o}, 32'd1);

        // 1 lane, len 4: 4 * 3*5
        start(2'b00, 1'b0, 16'd4);
        for (int k = 0; k < 4; k++) beat(32'd3, 32'd5, k == 3);
        check("t1_exp", last_exp, 32'd60);
        wait_idle();

        // 4 lanes, len 2; config changes on beat 2 must be ignored
        start(2'b01, 1'b0, 16'd2);
        beat(32'h01020304, 32'h01010101, 1'b0);
        vec_mode_i = 2'b00;
        sat_en_i   = 1'b1;
        acc_len_i  = 16'd7;
        beat(32'h01020304, 32'h01010101, 1'b1);
        wait_idle();

        // 4 lanes, len 1, saturate then wrap
        start(2'b01, 1'b1, 16'd1);
        beat(32'h64646464, 32'h02020202, 1'b1);
        check("t3_sat_exp", last_exp, 32'd508);
        wait_idle();
        start(2'b01, 1'b0, 16'd1);
        beat(32'h64646464, 32'h02020202, 1'b1);
        check("t3_wrap_exp", last_exp, 32'hFFFFFF20);
        wait_idle();

        // 2 lanes, len 3, consumer stalls for 5 cycles with a beat already waiting
        res_ready_i = 1'b0;
        start(2'b10, 1'b0, 16'd3);
        for (int k = 0; k < 3; k++) beat(32'h0010FFFE, 32'h00030005, k == 2);
        guard = 0;
        while (!stream_valid_o && guard < 20) begin
            @(posedge clk_i); #1;
            guard++;
        end
        check("hold_rise", {31'b0, stream_valid_o}, 32'd1);
        start(2'b00, 1'b0, 16'd1);
        drive(32'd7, 32'd6);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {31'b0, stream_valid_o}, 32'd1);
            check("hold_res", pe_res_o, last_exp);
            check("hold_in_ready", {31'b0, in_ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        res_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("hs_valid", {31'b0, stream_valid_o}, 32'd0);
        check("hs_in_ready", {31'b0, in_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        stream_valid_i = '0;
        model_beat(32'd7, 32'd6);
        e.res     = model_result();
        e.acc_cyc = cyc;
        e.lat     = 1;
        sb.push_back(e);
        model_clear();
        wait_idle();

        // len 0 behaves as len 1
        start(2'b00, 1'b0, 16'd0);
        beat(32'd2, 32'd3, 1'b1);
        beat(32'hFFFFFFFC, 32'd5, 1'b1);
        check("len0_exp", last_exp, 32'hFFFFFFEC);
        wait_idle();

        // a beat with one selected valid low is not counted
        start(2'b00, 1'b0, 16'd2);
        beat(32'd10, 32'd10, 1'b0);
        drive(32'd99, 32'd99);
        stream_valid_i[sel_b] = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        check("gap_no_valid", {31'b0, stream_valid_o}, 32'd0);
        beat(32'd3, 32'hFFFFFFFD, 1'b1);
        check("gap_exp", last_exp, 32'd91);
        wait_idle();

        // reset after 2 of 4 beats discards the partial sum
        start(2'b00, 1'b0, 16'd4);
        beat(32'd100, 32'd100, 1'b0);
        beat(32'd100, 32'd100, 1'b0);
        rst_n_i = 1'b0;
        #2;
        check("mid_rst_valid", {31'b0, stream_valid_o}, 32'd0);
        check("mid_rst_res", pe_res_o, 32'd0);
        rst_n_i = 1'b1;
        model_clear();
        @(posedge clk_i); #1;
        check("mid_rst_in_ready", {31'b0, in_ready_o}, 32'd1);
        for (int k = 0; k < 4; k++) beat(32'd3, 32'd5, k == 3);
        wait_idle();

        // randomised operands and selects across modes
        for (int t = 0; t < 3; t++) begin
            sel_a = 3'($urandom_range(0, 7));
            sel_b = 3'($urandom_range(0, 7));
            start((t == 0) ? 2'b10 : ((t == 1) ? 2'b01 : 2'b00), t != 1, 16'd3);
            for (int k = 0; k < 3; k++) beat($urandom, $urandom, k == 2);
            wait_idle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vacc_pe.md
Name: vacc_pe

Overview:
- Parametrised vector multiply-accumulate PE for the PEA, next generation of the accumulation PE.
- Owns its accumulation length counter. There is no external match strobe.
- Supports 1xN, 2x(N/2) and 4x(N/4) lanes, with optional per-lane saturation and a pipelined lane-reduction tree.
- Has a valid/ready output handshake with backpressure into the stream.

Parameters:
- N_BITS, 32: datapath width; must be divisible by 4.
- N_INPUTS_PE, 8: number of operand inputs to the select muxes.
- CNT_W, 16: width of the accumulation-length counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- pe_op_i  in  N_INPUTS_PE x N_BITS  operand inputs.
- stream_valid_i  in  N_INPUTS_PE  per-input valid.
- mux1_sel_i  in  $clog2(N_INPUTS_PE)  operand A select.
- mux2_sel_i  in  $clog2(N_INPUTS_PE)  operand B select.
- vec_mode_i  in  2  00=1 lane, 01=4 lanes of N/4, 10=2 lanes of N/2, 11 treated as 00.
- sat_en_i  in  1  1=saturate lanes, 0=wrap.
- acc_len_i  in  CNT_W  beats per accumulation; 0 treated as 1.
- in_ready_o  out  1  beat accepted this cycle when high together with both selected valids.
- res_ready_i  in  1  consumer ready.
- stream_valid_o  out  1  result valid.
- pe_res_o  out  N_BITS  reduced result, sign-extended.

Behaviour:
- Reset: all outputs 0; accumulator 0; counter 0; state ACC. Reset mid-operation discards the partial sum and any held result.
- Beat accept: state==ACC && stream_valid_i[mux1_sel_i] && stream_valid_i[mux2_sel_i]. in_ready_o = (state==ACC), combinational.
- Config capture: vec_mode_i, sat_en_i and acc_len_i are captured on the first beat (counter==0). Later changes within the same accumulation are ignored.
- Lane MAC per accepted beat, for each lane l of width W:
  - acc[l] <= f(acc[l] + a[l]*b[l]), all signed.
  - The full 2W product and the sum are computed at 2W+1 bits.
  - f: sat_en=1 clamps to [-2^(W-1), 2^(W-1)-1]; sat_en=0 keeps the low W bits.
  - The first beat uses acc=0. No state is carried over from the previous accumulation.
- Counter: increments per accepted beat. When counter reaches len-1 on an accepted beat: counter clears, the accumulator updates, and state leaves ACC.
- FSM: ACC -> RED2 (4-lane) | RED1 (2-lane) | HOLD (1-lane); RED2 -> RED1; RED1 -> HOLD; HOLD -> ACC when res_ready_i.
- Reduction (in RED states): stage 1 adds lane pairs with sign extension (exact). Stage 2 adds the two partials. The result is sign-extended to N_BITS with no saturation.
- Latency from the final beat accepted at edge t: stream_valid_o rises after t+1 in 1-lane, t+2 in 2-lane, t+3 in 4-lane mode.
- HOLD: stream_valid_o=1 and pe_res_o stable until res_ready_i. On the handshake cycle, valid drops next cycle, state returns to ACC, and the accumulator clears. No input is accepted during RED* or HOLD.
- A beat arriving in the same cycle as the HOLD handshake is not accepted; it is accepted from the next cycle.
- stream_valid_o is low whenever not in HOLD; pe_res_o keeps its last value.

Decomposition:
- pea_pkg adds:
  - vec_mode_t enum: VEC_NONE=2'b00, VEC_8=2'b01, VEC_16=2'b10.
  - vacc_state_t enum: ACC, RED2, RED1, HOLD.
  - Lane-count helper function.
- One sub-module, vacc_lane_mac: a combinational partitioned signed multiply-add with saturate/wrap, selected by vec_mode_t.
- Reduction tree, counter and FSM stay in vacc_pe.

Test Plan:
- 1-lane, len=4, a=3, b=5 every cycle, res_ready_i=1 -> pe_res_o=60; stream_valid_o high one cycle, one cycle after the 4th accept.
- 4-lane, len=2, a=0x01020304, b=0x01010101 -> lanes 2,4,6,8 -> pe_res_o=20; valid 3 cycles after the last accept.
- 4-lane, len=1, a lanes=100, b lanes=2: sat_en=1 -> lanes 127, pe_res_o=508. sat_en=0 -> lanes -56, pe_res_o=-224 (0xFFFFFF20).
- 2-lane, len=3, hold res_ready_i=0 for 5 cycles -> stream_valid_o and pe_res_o stable and in_ready_o=0 throughout; next accumulation starts only after the handshake.
- acc_len_i=0 -> each beat produces its own result; deassert one selected valid -> beat not counted.
- Assert rst_n_i after 2 of 4 beats -> outputs 0, state ACC; a fresh 4-beat run gives a result without residue.
